// File: rtl/dx_stage_latch.sv
// Decode-to-execute pipeline register with load-use interlock and
// multiply/divide start/wait sequencing.
module dx_stage_latch #(
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] IR_D,
  input  logic [31:0] PC_D,
  input  logic [31:0] A_D,
  input  logic [31:0] B_D,
  input  logic        flush,
  input  logic        md_ready,
  output logic [31:0] IR_X,
  output logic [31:0] PC_X,
  output logic [31:0] A_X,
  output logic [31:0] B_X,
  output logic        stall,
  output logic        md_start,
  output logic        md_busy
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 5;

  localparam logic [OP_W-1:0] OP_ALU  = 5'b00000;
  localparam logic [OP_W-1:0] OP_BNE  = 5'b00010;
  localparam logic [OP_W-1:0] OP_JR   = 5'b00100;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OP_W-1:0] OP_BLT  = 5'b00110;
  localparam logic [OP_W-1:0] OP_SW   = 5'b00111;
  localparam logic [OP_W-1:0] OP_LW   = 5'b01000;
  localparam logic [OP_W-1:0] ALU_MUL = 5'b00110;
  localparam logic [OP_W-1:0] ALU_DIV = 5'b00111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MD_START = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    X_LOAD = 2'd0,
    X_KILL = 2'd1,
    X_HOLD = 2'd2
  } xsel_t;

  state_t state, state_nxt;
  xsel_t  x_sel;

  logic [OP_W-1:0]  op_d, op_x;
  logic [REG_W-1:0] rs_d, rt_d, rd_d, rd_x, src2_d;
  logic             src1_used, src2_used;
  logic             x_is_lw, d_is_md, lu, md_hold;

  // Field extraction for the decode and execute instructions
  assign op_d = IR_D[31:27];
  assign rd_d = IR_D[26:22];
  assign rs_d = IR_D[21:17];
  assign rt_d = IR_D[16:12];
  assign op_x = IR_X[31:27];
  assign rd_x = IR_X[26:22];

  // Which register fields of the decode instruction are actually read
  always_comb begin
    src1_used = 1'b0;
    src2_used = 1'b0;
    src2_d    = rd_d;
    case (op_d)
      OP_ALU:  begin src1_used = 1'b1; src2_used = 1'b1; src2_d = rt_d; end
      OP_ADDI: begin src1_used = 1'b1; end
      OP_LW:   begin src1_used = 1'b1; end
      OP_SW:   begin src1_used = 1'b1; src2_used = 1'b1; end
      OP_BNE:  begin src1_used = 1'b1; src2_used = 1'b1; end
      OP_BLT:  begin src1_used = 1'b1; src2_used = 1'b1; end
      OP_JR:   begin src2_used = 1'b1; end
      default: begin src1_used = 1'b0; src2_used = 1'b0; end
    endcase
  end

  // A NOP word in X or D is excluded explicitly so a non-zero NOP stays inert
  assign x_is_lw = (IR_X != NOP) && (op_x == OP_LW);
  assign d_is_md = (IR_D != NOP) && (op_d == OP_ALU) &&
                   ((IR_D[6:2] == ALU_MUL) || (IR_D[6:2] == ALU_DIV));

  assign lu = x_is_lw && (rd_x != REG_W'(0)) &&
              ((src1_used && (rs_d == rd_x)) || (src2_used && (src2_d == rd_x)));

  assign md_hold = (state == MD_START) || ((state == MD_WAIT) && !md_ready);

  assign stall = md_hold || (!flush && lu);

  // X-register update selection and FSM next state
  always_comb begin
    x_sel     = X_LOAD;
    state_nxt = IDLE;
    if (md_hold) begin
      x_sel     = X_HOLD;
      state_nxt = MD_WAIT;
    end else if (flush || lu) begin
      x_sel = X_KILL;
    end else if (d_is_md) begin
      state_nxt = MD_START;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      md_start <= 1'b0;
      md_busy  <= 1'b0;
      IR_X     <= NOP;
      PC_X     <= XLEN'(0);
      A_X      <= XLEN'(0);
      B_X      <= XLEN'(0);
    end else begin
      state    <= state_nxt;
      md_start <= (state_nxt == MD_START);
      md_busy  <= (state_nxt != IDLE);
      case (x_sel)
        X_LOAD: begin
          IR_X <= IR_D;
          PC_X <= PC_D;
          A_X  <= A_D;
          B_X  <= B_D;
        end
        X_KILL: begin
          IR_X <= NOP;
          PC_X <= XLEN'(0);
          A_X  <= XLEN'(0);
          B_X  <= XLEN'(0);
        end
        default: begin
          IR_X <= IR_X;
          PC_X <= PC_X;
          A_X  <= A_X;
          B_X  <= B_X;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dx_stage_latch.sv
// Scoreboard bench for dx_stage_latch: each stimulus cycle queues the
// expected X-stage outputs, a negedge monitor pops and compares them.
module tb_dx_stage_latch;

  localparam logic [31:0] R0X    = 32'h0021_0000;
  localparam logic [31:0] LW3    = 32'h40C2_0000;
  localparam logic [31:0] ADD    = 32'h0106_2000;
  localparam logic [31:0] ADD_R5 = 32'h010A_0000;
  localparam logic [31:0] LWR0   = 32'h4002_0000;
  localparam logic [31:0] ADD00  = 32'h0100_0000;
  localparam logic [31:0] MUL    = 32'h0044_3018;
  localparam logic [31:0] DIV    = 32'h0044_301C;
  localparam logic [31:0] SW3    = 32'h38C2_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] IR_D = R0X, PC_D = 32'h0, A_D = 32'h0, B_D = 32'h0;
  logic        flush = 1'b0, md_ready = 1'b0;
  logic [31:0] IR_X, PC_X, A_X, B_X;
  logic        stall, md_start, md_busy;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic        st;
    logic        start;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dx_stage_latch #(.NOP(32'h0000_0000)) dut (
    .clock(clock), .reset_n(reset_n),
    .IR_D(IR_D), .PC_D(PC_D), .A_D(A_D), .B_D(B_D),
    .flush(flush), .md_ready(md_ready),
    .IR_X(IR_X), .PC_X(PC_X), .A_X(A_X), .B_X(B_X),
    .stall(stall), .md_start(md_start), .md_busy(md_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected during it
  task automatic step(input logic rst, input logic [31:0] ir, pc, a, b,
                      input logic fl, rdy,
                      input logic [31:0] eir, epc, ea, eb,
                      input logic est, estart, ebusy);
    exp_t e;
    @(posedge clock);
    #1;
    reset_n  = rst;
    IR_D     = ir;
    PC_D     = pc;
    A_D      = a;
    B_D      = b;
    flush    = fl;
    md_ready = rdy;
    e.ir = eir; e.pc = epc; e.a = ea; e.b = eb;
    e.st = est; e.start = estart; e.busy = ebusy;
    sb.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a state, compare against the queue
  initial begin
    exp_t e;
    int   cyc;
    cyc = 0;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cyc++;
        chk("ir_x",     cyc, IR_X, e.ir);
        chk("pc_x",     cyc, PC_X, e.pc);
        chk("a_x",      cyc, A_X,  e.a);
        chk("b_x",      cyc, B_X,  e.b);
        chk("stall",    cyc, 32'(stall),    32'(e.st));
        chk("md_start", cyc, 32'(md_start), 32'(e.start));
        chk("md_busy",  cyc, 32'(md_busy),  32'(e.busy));
      end
    end
  end

  initial begin
    // reset held two cycles
    step(0, R0X, 32'h100, 32'h11, 32'h22, 0, 0,  32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step(0, R0X, 32'h100, 32'h11, 32'h22, 0, 0,  32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step(1, R0X, 32'h100, 32'h11, 32'h22, 0, 0,  32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step(1, LW3, 32'h104, 32'h33, 32'h44, 0, 0,  R0X, 32'h100, 32'h11, 32'h22, 0, 0, 0);
    // load-use on rs
    step(1, ADD, 32'h108, 32'h55, 32'h66, 0, 0,  LW3, 32'h104, 32'h33, 32'h44, 1, 0, 0);
    step(1, ADD, 32'h108, 32'h55, 32'h66, 0, 0,  32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step(1, LW3, 32'h10C, 32'h77, 32'h88, 0, 0,  ADD, 32'h108, 32'h55, 32'h66, 0, 0, 0);
    // no hazard: unrelated source, and load to r0
    step(1, ADD_R5, 32'h110, 32'h1, 32'h2, 0, 0, LW3, 32'h10C, 32'h77, 32'h88, 0, 0, 0);
    step(1, LWR0,  32'h114, 32'h3, 32'h4, 0, 0,  ADD_R5, 32'h110, 32'h1, 32'h2, 0, 0, 0);
    step(1, ADD00, 32'h118, 32'h5, 32'h6, 0, 0,  LWR0, 32'h114, 32'h3, 32'h4, 0, 0, 0);
    step(1, LW3,   32'h11C, 32'h7, 32'h8, 0, 0,  ADD00, 32'h118, 32'h5, 32'h6, 0, 0, 0);
    // flush together with load-use
    step(1, ADD,   32'h120, 32'h9, 32'hA, 1, 0,  LW3, 32'h11C, 32'h7, 32'h8, 0, 0, 0);
    step(1, MUL,   32'h200, 32'h1234, 32'h5678, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    // mul: ready ignored in MD_START, then four waiting cycles
    step(1, R0X, 32'h204, 32'hA, 32'hB, 0, 1,  MUL, 32'h200, 32'h1234, 32'h5678, 1, 1, 1);
    step(1, R0X, 32'h204, 32'hA, 32'hB, 0, 0,  MUL, 32'h200, 32'h1234, 32'h5678, 1, 0, 1);
    step(1, R0X, 32'h204, 32'hA, 32'hB, 0, 0,  MUL, 32'h200, 32'h1234, 32'h5678, 1, 0, 1);
    step(1, R0X, 32'h204, 32'hA, 32'hB, 0, 0,  MUL, 32'h200, 32'h1234, 32'h5678, 1, 0, 1);
    step(1, R0X, 32'h204, 32'hA, 32'hB, 0, 0,  MUL, 32'h200, 32'h1234, 32'h5678, 1, 0, 1);
    step(1, R0X, 32'h204, 32'hA, 32'hB, 0, 1,  MUL, 32'h200, 32'h1234, 32'h5678, 0, 0, 1);
    step(1, MUL, 32'h300, 32'h1, 32'h2, 0, 1,  R0X, 32'h204, 32'hA, 32'hB, 0, 0, 0);
    // back-to-back mul then div
    step(1, DIV, 32'h304, 32'h3, 32'h4, 0, 1,  MUL, 32'h300, 32'h1, 32'h2, 1, 1, 1);
    step(1, DIV, 32'h304, 32'h3, 32'h4, 0, 0,  MUL, 32'h300, 32'h1, 32'h2, 1, 0, 1);
    step(1, DIV, 32'h304, 32'h3, 32'h4, 0, 1,  MUL, 32'h300, 32'h1, 32'h2, 0, 0, 1);
    step(1, R0X, 32'h308, 32'h5, 32'h6, 0, 1,  DIV, 32'h304, 32'h3, 32'h4, 1, 1, 1);
    step(1, R0X, 32'h308, 32'h5, 32'h6, 0, 1,  DIV, 32'h304, 32'h3, 32'h4, 0, 0, 1);
    step(1, MUL, 32'h400, 32'h7, 32'h8, 0, 1,  R0X, 32'h308, 32'h5, 32'h6, 0, 0, 0);
    // reset while in MD_WAIT, later ready ignored
    step(1, R0X, 32'h404, 32'h9, 32'h9, 0, 0,  MUL, 32'h400, 32'h7, 32'h8, 1, 1, 1);
    step(0, R0X, 32'h404, 32'h9, 32'h9, 0, 0,  MUL, 32'h400, 32'h7, 32'h8, 1, 0, 1);
    step(1, R0X, 32'h404, 32'h9, 32'h9, 0, 1,  32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    // load-use through the store's rd source
    step(1, LW3, 32'h500, 32'hC, 32'hD, 0, 0,  R0X, 32'h404, 32'h9, 32'h9, 0, 0, 0);
    step(1, SW3, 32'h504, 32'hE, 32'hF, 0, 0,  LW3, 32'h500, 32'hC, 32'hD, 1, 0, 0);
    step(1, SW3, 32'h504, 32'hE, 32'hF, 0, 0,  32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step(1, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0,  SW3, 32'h504, 32'hE, 32'hF, 0, 0, 0);

    repeat (3) @(negedge clock);
    chk("scoreboard_drain", 0, 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
